npu_tile_scheduler: RTL and testbench
=====================================

NPU_TILE_SCHEDULER -- requirements
Module: npu_tile_scheduler

Interface
REQ-001 SHALL have parameter NUM_LARGE_ARRAYS, default 4: number of clusters scheduled.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of dimension, index and address values.
REQ-003 SHALL have parameter TILE_DIM, default 2: output tile edge; power of two.
REQ-004 SHALL have ports (SZ = $clog2(TILE_DIM+1)):
 clk  in  1  clock;
 rst_n  in  1  reset, asynchronous, active-low;
 ctrl_start  in  1  start pulse;
 ctrl_clear  in  1  abort/clear pulse;
 cluster_enable  in  NUM_LARGE_ARRAYS  clusters usable;
 dim_m, dim_k, dim_n  in  DATA_WIDTH each  GEMM dimensions;
 addr_input, addr_weight, addr_output  in  DATA_WIDTH each  base addresses;
 tile_valid  out  NUM_LARGE_ARRAYS  one-hot per-cluster offer;
 tile_ready  in  NUM_LARGE_ARRAYS  per-cluster accept;
 tile_row, tile_col  out  DATA_WIDTH each  tile origin;
 tile_m_sz, tile_n_sz  out  SZ each  tile extent;
 tile_addr_in, tile_addr_w, tile_addr_out  out  DATA_WIDTH each  tile addresses;
 tile_done  in  NUM_LARGE_ARRAYS  per-cluster completion pulse;
 status_busy, status_done, status_error  out  1 each  status.

Function
REQ-005 SHALL use states IDLE, DISPATCH, DRAIN; status_busy = (state != IDLE).
REQ-006 SHALL accept ctrl_start only in IDLE; sample dims, bases, cluster_enable into internal registers on acceptance; ignore start otherwise.
REQ-007 SHALL, on accepted start with any dim zero or sampled enable all-zero, set status_error, stay IDLE, leave status_done 0.
REQ-008 SHALL, on valid accepted start, clear status_done/status_error, enter DISPATCH; first tile_valid the next cycle.
REQ-009 SHALL order tiles row-major: tile_col steps by TILE_DIM to >= dim_n, then tile_row steps by TILE_DIM to >= dim_m.
REQ-010 SHALL drive tile_m_sz = min(TILE_DIM, dim_m - tile_row), tile_n_sz = min(TILE_DIM, dim_n - tile_col).
REQ-011 SHALL drive tile_addr_in = addr_input + tile_row*dim_k, tile_addr_w = addr_weight + tile_col, tile_addr_out = addr_output + tile_row*dim_n + tile_col, modulo 2^DATA_WIDTH; incremental accumulation permitted, no combinational multiplier required.
REQ-012 SHALL grant round-robin among clusters that are sampled-enabled and not busy, searching from last-granted+1; after reset search starts at cluster 0.
REQ-013 SHALL hold tile_valid and all tile_* payload stable until tile_ready of the granted cluster; no re-arbitration while pending.
REQ-014 SHALL, on handshake, mark that cluster busy and advance to next tile; after last tile handshake go to DRAIN.
REQ-015 SHALL clear a cluster's busy bit on its tile_done; a cluster freed this cycle is grantable next cycle, not same cycle.
REQ-016 SHALL, in DRAIN, return to IDLE and set status_done when no cluster busy.
REQ-017 SHALL, on tile_done from a non-busy cluster, set status_error, ignore the pulse, continue operation.
REQ-018 SHALL, on ctrl_clear in any state, next cycle: go to IDLE, deassert tile_valid, clear busy bits, status_done, status_error; clear wins over simultaneous start.
REQ-019 SHALL keep status_done and status_error sticky until next accepted start or clear.

Reset
REQ-020 SHALL on rst_n low: state IDLE, tile_valid 0, all tile_* outputs 0, busy bits 0, rr pointer 0, status_busy/done/error 0.

Structure
REQ-021 SHALL take state enum type and TILE_DIM default from shared npu_pkg.
REQ-022 SHALL instantiate one sub-module npu_rr_arbiter (request vector, advance-on-grant, one-hot grant).

Verification
REQ-023 M=4,N=4,K=8, bases 0x100/0x200/0x300, 4 clusters, ready=1, no done -> tiles (0,0),(0,2),(2,0),(2,2) to clusters 0,1,2,3 on consecutive cycles; last tile_addr_in=0x110, tile_addr_w=0x202, tile_addr_out=0x30A; DRAIN until 4 done pulses, then status_done=1.
REQ-024 M=3,N=1,K=1, cluster_enable=4'b0010 -> tile (0,0) sz 2x1, then (2,0) sz 1x1, both to cluster 1, second only after cluster 1 done+1 cycle.
REQ-025 tile_ready low 5 cycles -> tile_valid and payload unchanged all 5 cycles, single handshake.
REQ-026 start with dim_k=0 -> status_error=1, status_busy=0, no tile_valid.
REQ-027 clear during DISPATCH with 2 busy clusters -> IDLE next cycle, tile_valid=0, status_* 0; new start then begins at tile (0,0).
REQ-028 tile_done on idle cluster 3 mid-job -> status_error=1, job still completes with status_done=1.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: shared scheduler state encoding and default tile edge.
// Exports state_t (IDLE/DISPATCH/DRAIN) and TILE_DIM_DEF.
package npu_pkg;
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
    localparam int TILE_DIM_DEF = 2;
endpackage

// File: rtl/npu_rr_arbiter.sv
// npu_rr_arbiter: round-robin one-hot arbiter.
// Ports: clk, rst_n (async active-low), req (request vector),
// adv (commit current grant, move search start past it), grant (one-hot).
module npu_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] grant
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    // Scan offsets high to low so the request nearest to ptr wins.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (adv && |req)
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
endmodule

// File: rtl/npu_tile_scheduler.sv
// npu_tile_scheduler: splits an M x N GEMM output into TILE_DIM tiles, offers them to clusters.
// Ports: clk, rst_n; ctrl_start/ctrl_clear; cluster_enable; dim_m/k/n; addr_input/weight/output;
// tile_valid/tile_ready handshake with tile_row/col, tile_m_sz/n_sz, tile_addr_in/w/out;
// tile_done completion pulses; status_busy/done/error.
module npu_tile_scheduler
    import npu_pkg::*;
#(
    parameter int NUM_LARGE_ARRAYS = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int TILE_DIM         = TILE_DIM_DEF,
    localparam int SZ              = $clog2(TILE_DIM + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ctrl_start,
    input  logic                        ctrl_clear,
    input  logic [NUM_LARGE_ARRAYS-1:0] cluster_enable,
    input  logic [DATA_WIDTH-1:0]       dim_m,
    input  logic [DATA_WIDTH-1:0]       dim_k,
    input  logic [DATA_WIDTH-1:0]       dim_n,
    input  logic [DATA_WIDTH-1:0]       addr_input,
    input  logic [DATA_WIDTH-1:0]       addr_weight,
    input  logic [DATA_WIDTH-1:0]       addr_output,
    output logic [NUM_LARGE_ARRAYS-1:0] tile_valid,
    input  logic [NUM_LARGE_ARRAYS-1:0] tile_ready,
    output logic [DATA_WIDTH-1:0]       tile_row,
    output logic [DATA_WIDTH-1:0]       tile_col,
    output logic [SZ-1:0]               tile_m_sz,
    output logic [SZ-1:0]               tile_n_sz,
    output logic [DATA_WIDTH-1:0]       tile_addr_in,
    output logic [DATA_WIDTH-1:0]       tile_addr_w,
    output logic [DATA_WIDTH-1:0]       tile_addr_out,
    input  logic [NUM_LARGE_ARRAYS-1:0] tile_done,
    output logic                        status_busy,
    output logic                        status_done,
    output logic                        status_error
);
    localparam logic [DATA_WIDTH-1:0] TD  = DATA_WIDTH'(TILE_DIM);
    localparam logic [SZ-1:0]         TDS = SZ'(TILE_DIM);
    localparam int                    TS  = $clog2(TILE_DIM);
    state_t state;
    logic [NUM_LARGE_ARRAYS-1:0] busy, en_r, req, grant;
    logic [DATA_WIDTH-1:0] m_r, k_r, n_r, aw_r;
    // Cursor of the next tile to offer; nain/naout already include row*dim_k / row*dim_n.
    logic [DATA_WIDTH-1:0] nrow, ncol, nain, naout;
    logic more;
    logic idle, start_ok, hs, load, last_col, last_row;
    logic [DATA_WIDTH-1:0] c_m, c_k, c_n, c_aw, c_row, c_col, c_ain, c_aout, rem_m, rem_n;
    assign idle        = (state == IDLE);
    assign status_busy = !idle;
    assign start_ok    = ctrl_start && idle && !ctrl_clear && |cluster_enable &&
                         |dim_m && |dim_k && |dim_n;
    // On the start cycle the first tile is built straight from the inputs so it is offered next cycle.
    assign c_m    = idle ? dim_m       : m_r;
    assign c_k    = idle ? dim_k       : k_r;
    assign c_n    = idle ? dim_n       : n_r;
    assign c_aw   = idle ? addr_weight : aw_r;
    assign c_row  = idle ? '0          : nrow;
    assign c_col  = idle ? '0          : ncol;
    assign c_ain  = idle ? addr_input  : nain;
    assign c_aout = idle ? addr_output : naout;
    assign rem_m    = c_m - c_row;
    assign rem_n    = c_n - c_col;
    assign last_col = rem_n <= TD;
    assign last_row = rem_m <= TD;
    assign hs       = |(tile_valid & tile_ready);
    // Cluster handshaking this cycle is busy from now on; freed clusters count from next cycle.
    assign req  = idle ? cluster_enable : en_r & ~busy & ~(hs ? tile_valid : '0);
    assign load = !ctrl_clear && |grant &&
                  (start_ok || (state == DISPATCH && more && (!(|tile_valid) || hs)));
    npu_rr_arbiter #(.N(NUM_LARGE_ARRAYS)) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .adv  (load),
        .grant(grant)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tile_valid    <= '0;
            tile_row      <= '0;
            tile_col      <= '0;
            tile_m_sz     <= '0;
            tile_n_sz     <= '0;
            tile_addr_in  <= '0;
            tile_addr_w   <= '0;
            tile_addr_out <= '0;
            busy          <= '0;
            en_r          <= '0;
            m_r           <= '0;
            k_r           <= '0;
            n_r           <= '0;
            aw_r          <= '0;
            nrow          <= '0;
            ncol          <= '0;
            nain          <= '0;
            naout         <= '0;
            more          <= 1'b0;
            status_done   <= 1'b0;
            status_error  <= 1'b0;
        end else if (ctrl_clear) begin
            state        <= IDLE;
            tile_valid   <= '0;
            busy         <= '0;
            more         <= 1'b0;
            status_done  <= 1'b0;
            status_error <= 1'b0;
        end else begin
            busy <= (busy & ~tile_done) | (hs ? tile_valid : '0);
            if (|(tile_done & ~busy))
                status_error <= 1'b1;
            if (ctrl_start && idle) begin
                m_r          <= dim_m;
                k_r          <= dim_k;
                n_r          <= dim_n;
                aw_r         <= addr_weight;
                en_r         <= cluster_enable;
                status_done  <= 1'b0;
                status_error <= !start_ok;
                if (start_ok) begin
                    state <= DISPATCH;
                    more  <= 1'b1;
                end
            end
            if (hs)
                tile_valid <= '0;
            if (state == DISPATCH && hs && !more)
                state <= DRAIN;
            if (state == DRAIN && !(|busy)) begin
                state       <= IDLE;
                status_done <= 1'b1;
            end
            if (load) begin
                tile_valid    <= grant;
                tile_row      <= c_row;
                tile_col      <= c_col;
                tile_m_sz     <= (rem_m < TD) ? rem_m[SZ-1:0] : TDS;
                tile_n_sz     <= (rem_n < TD) ? rem_n[SZ-1:0] : TDS;
                tile_addr_in  <= c_ain;
                tile_addr_w   <= c_aw + c_col;
                tile_addr_out <= c_aout + c_col;
                more          <= !(last_col && last_row);
                nrow          <= last_col ? c_row + TD : c_row;
                ncol          <= last_col ? '0 : c_col + TD;
                nain          <= last_col ? c_ain + (c_k << TS) : c_ain;
                naout         <= last_col ? c_aout + (c_n << TS) : c_aout;
            end
        end
    end
endmodule

// File: tb/tb_npu_tile_scheduler.sv
// tb_npu_tile_scheduler: directed self-checking bench for npu_tile_scheduler.
module tb_npu_tile_scheduler;
    logic        clk = 0;
    logic        rst_n;
    logic        ctrl_start, ctrl_clear;
    logic [3:0]  cluster_enable, tile_valid, tile_ready, tile_done;
    logic [31:0] dim_m, dim_k, dim_n, addr_input, addr_weight, addr_output;
    logic [31:0] tile_row, tile_col, tile_addr_in, tile_addr_w, tile_addr_out;
    logic [1:0]  tile_m_sz, tile_n_sz;
    logic        status_busy, status_done, status_error;
    int n_chk = 0;
    int n_pass = 0;

    npu_tile_scheduler dut (
        .clk(clk), .rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_clear(ctrl_clear),
        .cluster_enable(cluster_enable), .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .addr_input(addr_input), .addr_weight(addr_weight), .addr_output(addr_output),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_row(tile_row), .tile_col(tile_col),
        .tile_m_sz(tile_m_sz), .tile_n_sz(tile_n_sz), .tile_addr_in(tile_addr_in),
        .tile_addr_w(tile_addr_w), .tile_addr_out(tile_addr_out), .tile_done(tile_done),
        .status_busy(status_busy), .status_done(status_done), .status_error(status_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_job(input logic [31:0] m, input logic [31:0] n, input logic [31:0] k,
                             input logic [3:0] en);
        dim_m = m; dim_n = n; dim_k = k; cluster_enable = en;
        ctrl_start = 1;
        @(negedge clk);
        ctrl_start = 0;
    endtask

    task automatic done_pulse(input logic [3:0] mask);
        tile_done = mask;
        @(negedge clk);
        tile_done = 0;
    endtask

    task automatic tile(input string tag, input logic [3:0] v, input logic [31:0] r,
                        input logic [31:0] c, input logic [1:0] ms, input logic [1:0] ns,
                        input logic [31:0] ain, input logic [31:0] aw, input logic [31:0] aout);
        chk({tag, ".valid"}, tile_valid, v);
        chk({tag, ".row"}, tile_row, r);
        chk({tag, ".col"}, tile_col, c);
        chk({tag, ".msz"}, tile_m_sz, ms);
        chk({tag, ".nsz"}, tile_n_sz, ns);
        chk({tag, ".ain"}, tile_addr_in, ain);
        chk({tag, ".aw"}, tile_addr_w, aw);
        chk({tag, ".aout"}, tile_addr_out, aout);
    endtask

    initial begin
        rst_n = 0; ctrl_start = 0; ctrl_clear = 0; cluster_enable = 0;
        tile_ready = 0; tile_done = 0; dim_m = 0; dim_k = 0; dim_n = 0;
        addr_input = 32'h100; addr_weight = 32'h200; addr_output = 32'h300;
        repeat (3) @(negedge clk);
        chk("rst.valid", tile_valid, 0);
        chk("rst.busy", status_busy, 0);
        chk("rst.done", status_done, 0);
        chk("rst.err", status_error, 0);
        chk("rst.ain", tile_addr_in, 0);
        rst_n = 1;
        @(negedge clk);

        // Four tiles to four clusters on consecutive cycles, then drain.
        tile_ready = 4'hF;
        start_job(4, 4, 8, 4'hF);
        tile("t1a", 4'b0001, 0, 0, 2, 2, 32'h100, 32'h200, 32'h300);
        @(negedge clk);
        tile("t1b", 4'b0010, 0, 2, 2, 2, 32'h100, 32'h202, 32'h302);
        @(negedge clk);
        tile("t1c", 4'b0100, 2, 0, 2, 2, 32'h110, 32'h200, 32'h308);
        @(negedge clk);
        tile("t1d", 4'b1000, 2, 2, 2, 2, 32'h110, 32'h202, 32'h30A);
        @(negedge clk);
        chk("t1.drain_valid", tile_valid, 0);
        chk("t1.drain_busy", status_busy, 1);
        done_pulse(4'b0001);
        done_pulse(4'b0010);
        done_pulse(4'b0100);
        chk("t1.not_done", status_done, 0);
        chk("t1.still_busy", status_busy, 1);
        done_pulse(4'b1000);
        @(negedge clk);
        chk("t1.done", status_done, 1);
        chk("t1.idle", status_busy, 0);
        chk("t1.err", status_error, 0);

        // Single enabled cluster: second tile waits for its done.
        start_job(3, 1, 1, 4'b0010);
        chk("t2.done_cleared", status_done, 0);
        tile("t2a", 4'b0010, 0, 0, 2, 1, 32'h100, 32'h200, 32'h300);
        repeat (3) @(negedge clk);
        chk("t2.wait_valid", tile_valid, 0);
        done_pulse(4'b0010);
        chk("t2.freed_not_same", tile_valid, 0);
        @(negedge clk);
        tile("t2b", 4'b0010, 2, 0, 1, 1, 32'h102, 32'h200, 32'h302);
        @(negedge clk);
        chk("t2.drain_valid", tile_valid, 0);
        done_pulse(4'b0010);
        @(negedge clk);
        chk("t2.done", status_done, 1);

        // Backpressure: offer held stable for 5 cycles; rr pointer now at cluster 2.
        tile_ready = 0;
        start_job(4, 4, 8, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tile($sformatf("t3hold%0d", i), 4'b0100, 0, 0, 2, 2, 32'h100, 32'h200, 32'h300);
            @(negedge clk);
        end
        tile_ready = 4'b0100;
        @(negedge clk);
        tile_ready = 0;
        tile("t3b", 4'b1000, 0, 2, 2, 2, 32'h100, 32'h202, 32'h302);
        @(negedge clk);
        chk("t3.single_hs", tile_col, 2);
        tile_ready = 4'b1000;
        @(negedge clk);
        tile_ready = 0;
        tile("t3c", 4'b0001, 2, 0, 2, 2, 32'h110, 32'h200, 32'h308);

        // Clear mid-dispatch with clusters 2 and 3 busy.
        ctrl_clear = 1;
        @(negedge clk);
        ctrl_clear = 0;
        chk("t4.valid", tile_valid, 0);
        chk("t4.busy", status_busy, 0);
        chk("t4.done", status_done, 0);
        chk("t4.err", status_error, 0);
        tile_ready = 4'hF;
        start_job(4, 4, 8, 4'hF);
        tile("t4a", 4'b0010, 0, 0, 2, 2, 32'h100, 32'h200, 32'h300);
        @(negedge clk);
        chk("t4b.valid", tile_valid, 4'b0100);
        @(negedge clk);
        chk("t4c.valid", tile_valid, 4'b1000);
        @(negedge clk);
        chk("t4d.valid", tile_valid, 4'b0001);
        chk("t4d.row", tile_row, 2);
        chk("t4d.col", tile_col, 2);
        @(negedge clk);
        done_pulse(4'hF);
        @(negedge clk);
        chk("t4.done2", status_done, 1);

        // Spurious done from idle cluster 3 flags error but the job completes.
        start_job(4, 4, 8, 4'b0011);
        chk("t5a.valid", tile_valid, 4'b0010);
        @(negedge clk);
        chk("t5b.valid", tile_valid, 4'b0001);
        @(negedge clk);
        chk("t5.stall", tile_valid, 0);
        done_pulse(4'b1000);
        chk("t5.err", status_error, 1);
        chk("t5.busy", status_busy, 1);
        done_pulse(4'b0011);
        @(negedge clk);
        tile("t5c", 4'b0010, 2, 0, 2, 2, 32'h110, 32'h200, 32'h308);
        @(negedge clk);
        tile("t5d", 4'b0001, 2, 2, 2, 2, 32'h110, 32'h202, 32'h30A);
        @(negedge clk);
        done_pulse(4'b0011);
        @(negedge clk);
        chk("t5.done", status_done, 1);
        chk("t5.err_sticky", status_error, 1);

        // Clear beats a simultaneous valid start.
        dim_m = 4; dim_n = 4; dim_k = 8; cluster_enable = 4'hF;
        ctrl_clear = 1; ctrl_start = 1;
        @(negedge clk);
        ctrl_clear = 0; ctrl_start = 0;
        chk("t6.busy", status_busy, 0);
        chk("t6.err", status_error, 0);
        chk("t6.done", status_done, 0);
        @(negedge clk);
        chk("t6.valid", tile_valid, 0);

        // Zero dimension: error, stay idle, no offer.
        start_job(4, 4, 0, 4'hF);
        chk("t7.err", status_error, 1);
        chk("t7.busy", status_busy, 0);
        chk("t7.done", status_done, 0);
        chk("t7.valid", tile_valid, 0);
        @(negedge clk);
        chk("t7.valid2", tile_valid, 0);

        // All-zero enable also rejected.
        start_job(4, 4, 8, 4'b0000);
        chk("t8.err", status_error, 1);
        chk("t8.busy", status_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
